// File: rtl/brief_desc_scheduler.sv
// Buffers flagged BRIEF results in a small FIFO and streams each 256-bit descriptor as WORD_W-bit beats.
// Optional build macro BRIEF_SCORE_THRESH_EN adds a score threshold filter ahead of the cap and full checks.
module brief_desc_scheduler #(
  parameter int DEPTH  = 8,
  parameter int WORD_W = 32,
  parameter int MAX_KP = 1023
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_frame_start,
  input  logic                              i_frame_end,
  input  logic                              i_flag,
  input  logic [9:0]                        i_coor_x,
  input  logic [9:0]                        i_coor_y,
  input  logic [7:0]                        i_score,
  input  logic [9:0]                        i_depth,
  input  logic [255:0]                      i_descriptor,
`ifdef BRIEF_SCORE_THRESH_EN
  input  logic [7:0]                        i_score_thresh,
`endif
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [WORD_W-1:0]                 o_word,
  output logic [$clog2(256/WORD_W)-1:0]     o_beat,
  output logic                              o_last,
  output logic [9:0]                        o_kp_x,
  output logic [9:0]                        o_kp_y,
  output logic [7:0]                        o_kp_score,
  output logic [9:0]                        o_kp_depth,
  output logic                              o_frame_done,
  output logic [9:0]                        o_kp_count,
  output logic [9:0]                        o_drop_count,
  output logic                              o_overflow,
  output logic [1:0]                        o_state
);

  localparam int NBEATS = 256 / WORD_W;
  localparam int BW     = $clog2(NBEATS);
  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = PW + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [9:0]    CAP       = 10'(MAX_KP);
  localparam logic [9:0]    SAT       = 10'd1023;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SEND  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  // Handshake: a beat transfers on a cycle where o_valid && i_ready; while i_ready is low
  // o_valid, o_word, o_beat, o_last and o_kp_* hold their values.

  logic [255:0]  mem_desc [DEPTH];
  logic [37:0]   mem_meta [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nx;
  logic [1:0]    state, state_nx;
  logic [BW-1:0] beat;
  logic [9:0]    acc_cnt, kp_cnt, drop_cnt;
  logic          ovf, fe_pend;

  logic          pass, under_cap, full, push, drop;
  logic          send, fire, last, pop;
  logic [255:0]  head_desc;
  logic [37:0]   head_meta;

`ifdef BRIEF_SCORE_THRESH_EN
  assign pass = (i_score >= i_score_thresh);
`else
  assign pass = 1'b1;
`endif

  // A frame start resets the cap, so a same-cycle push is judged against the new frame.
  assign under_cap = i_frame_start || (acc_cnt < CAP);
  assign full      = (count == FULL);
  assign push      = i_flag && pass && under_cap && !full;
  assign drop      = i_flag && pass && under_cap && full;

  assign send = (state == S_SEND);
  assign fire = send && i_ready;
  assign last = (beat == LAST_BEAT);
  assign pop  = fire && last;

  assign head_desc = mem_desc[rd_ptr];
  assign head_meta = mem_meta[rd_ptr];

  always_comb begin
    count_nx = count;
    if (push && !pop)
      count_nx = count + CW'(1);
    else if (pop && !push)
      count_nx = count - CW'(1);
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (count != '0)
          state_nx = S_SEND;
        else if (fe_pend && !push && !i_frame_start)
          state_nx = S_DRAIN;
      end
      S_SEND:  if (pop && count_nx == '0) state_nx = S_IDLE;
      S_DRAIN: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_desc[wr_ptr] <= i_descriptor;
      mem_meta[wr_ptr] <= {i_coor_x, i_coor_y, i_score, i_depth};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= S_IDLE;
      beat   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (fire) beat <= last ? '0 : beat + BW'(1);
    end
  end

  // Per-frame statistics; events coinciding with a frame start count toward the new frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_cnt  <= '0;
      kp_cnt   <= '0;
      drop_cnt <= '0;
      ovf      <= 1'b0;
      fe_pend  <= 1'b0;
    end else if (i_frame_start) begin
      acc_cnt  <= push ? 10'd1 : 10'd0;
      kp_cnt   <= pop  ? 10'd1 : 10'd0;
      drop_cnt <= drop ? 10'd1 : 10'd0;
      ovf      <= drop;
      fe_pend  <= 1'b0;
    end else begin
      if (push) acc_cnt <= acc_cnt + 10'd1;
      if (pop && kp_cnt != SAT) kp_cnt <= kp_cnt + 10'd1;
      if (drop && drop_cnt != SAT) drop_cnt <= drop_cnt + 10'd1;
      if (drop) ovf <= 1'b1;
      if (i_frame_end)
        fe_pend <= 1'b1;
      else if (state == S_DRAIN)
        fe_pend <= 1'b0;
    end
  end

  assign o_valid      = send;
  assign o_word       = send ? head_desc[int'(beat) * WORD_W +: WORD_W] : '0;
  assign o_beat       = beat;
  assign o_last       = send && last;
  assign o_kp_x       = send ? head_meta[37:28] : '0;
  assign o_kp_y       = send ? head_meta[27:18] : '0;
  assign o_kp_score   = send ? head_meta[17:10] : '0;
  assign o_kp_depth   = send ? head_meta[9:0]   : '0;
  assign o_frame_done = (state == S_DRAIN);
  assign o_kp_count   = kp_cnt;
  assign o_drop_count = drop_cnt;
  assign o_overflow   = ovf;
  assign o_state      = state;

endmodule

// File: tb/tb_brief_desc_scheduler.sv
// Directed bench for brief_desc_scheduler: a record scoreboard checks every beat, plus a small-cap
// second instance sharing the same stimulus for the per-frame keypoint limit.
module tb_brief_desc_scheduler;

  localparam int MAIN_MAX = 1023;
  localparam int REC_W    = 294;

  logic         clk = 1'b0;
  logic         i_rst, i_frame_start, i_frame_end, i_flag, i_ready;
  logic [9:0]   i_coor_x, i_coor_y, i_depth;
  logic [7:0]   i_score;
  logic [255:0] i_descriptor;

  logic         o_valid, o_last, o_frame_done, o_overflow;
  logic [31:0]  o_word;
  logic [2:0]   o_beat;
  logic [9:0]   o_kp_x, o_kp_y, o_kp_depth, o_kp_count, o_drop_count;
  logic [7:0]   o_kp_score;
  logic [1:0]   o_state;

  logic         c_valid, c_last, c_frame_done, c_overflow;
  logic [31:0]  c_word;
  logic [2:0]   c_beat;
  logic [9:0]   c_kp_x, c_kp_y, c_kp_depth, c_kp_count, c_drop_count;
  logic [7:0]   c_kp_score;
  logic [1:0]   c_state;

  int vectors = 0;
  int fails   = 0;

  logic [REC_W-1:0] exp_q[$];
  logic [REC_W-1:0] mon_rec;
  int exp_beat = 0, exp_kp = 0, acc_cnt = 0, exp_drop = 0;
  logic exp_ovf = 1'b0;
  int fd_seen = 0, cap_emit = 0, cap_fd = 0;
  logic cap_chk = 1'b0;

  brief_desc_scheduler dut (
    .i_clk(clk), .i_rst(i_rst), .i_frame_start(i_frame_start), .i_frame_end(i_frame_end),
    .i_flag(i_flag), .i_coor_x(i_coor_x), .i_coor_y(i_coor_y), .i_score(i_score),
    .i_depth(i_depth), .i_descriptor(i_descriptor),
`ifdef BRIEF_SCORE_THRESH_EN
    .i_score_thresh(8'd0),
`endif
    .o_valid(o_valid), .i_ready(i_ready), .o_word(o_word), .o_beat(o_beat), .o_last(o_last),
    .o_kp_x(o_kp_x), .o_kp_y(o_kp_y), .o_kp_score(o_kp_score), .o_kp_depth(o_kp_depth),
    .o_frame_done(o_frame_done), .o_kp_count(o_kp_count), .o_drop_count(o_drop_count),
    .o_overflow(o_overflow), .o_state(o_state)
  );

  brief_desc_scheduler #(.MAX_KP(3)) cap_dut (
    .i_clk(clk), .i_rst(i_rst), .i_frame_start(i_frame_start), .i_frame_end(i_frame_end),
    .i_flag(i_flag), .i_coor_x(i_coor_x), .i_coor_y(i_coor_y), .i_score(i_score),
    .i_depth(i_depth), .i_descriptor(i_descriptor),
`ifdef BRIEF_SCORE_THRESH_EN
    .i_score_thresh(8'd0),
`endif
    .o_valid(c_valid), .i_ready(i_ready), .o_word(c_word), .o_beat(c_beat), .o_last(c_last),
    .o_kp_x(c_kp_x), .o_kp_y(c_kp_y), .o_kp_score(c_kp_score), .o_kp_depth(c_kp_depth),
    .o_frame_done(c_frame_done), .o_kp_count(c_kp_count), .o_drop_count(c_drop_count),
    .o_overflow(c_overflow), .o_state(c_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("miscompare in %s", tag);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_beat = 0; exp_kp = 0; acc_cnt = 0; exp_drop = 0; exp_ovf = 1'b0;
    cap_emit = 0; cap_fd = 0;
  endtask

  function automatic logic [255:0] rand_desc();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Driver tasks: called at #1 after a rising edge, they return at #1 after the next one.
  task automatic push(input logic [9:0] x, input logic [9:0] y, input logic [7:0] s,
                      input logic [9:0] dp, input logic [255:0] desc, input logic fe);
    i_flag = 1'b1; i_coor_x = x; i_coor_y = y; i_score = s; i_depth = dp;
    i_descriptor = desc; i_frame_end = fe;
    if (acc_cnt < MAIN_MAX) begin
      if (exp_q.size() < 8) begin
        exp_q.push_back({x, y, s, dp, desc});
        acc_cnt++;
      end else begin
        if (exp_drop < 1023) exp_drop++;
        exp_ovf = 1'b1;
      end
    end
    @(posedge clk); #1;
    i_flag = 1'b0; i_frame_end = 1'b0;
  endtask

  task automatic push_rand(input logic fe);
    push(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
         8'($urandom_range(0, 255)), 10'($urandom_range(0, 1023)), rand_desc(), fe);
  endtask

  task automatic frame_start();
    i_frame_start = 1'b1;
    acc_cnt = 0; exp_kp = 0; exp_drop = 0; exp_ovf = 1'b0;
    @(posedge clk); #1;
    i_frame_start = 1'b0;
  endtask

  task automatic frame_end();
    i_frame_end = 1'b1;
    @(posedge clk); #1;
    i_frame_end = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int maxc);
    int n = 0;
    while ((exp_q.size() != 0 || o_valid) && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 256'(n < maxc), 256'(1));
  endtask

  task automatic wait_fd(input string tag, input int maxc);
    int n = 0;
    int start = fd_seen;
    while (fd_seen == start && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 256'(n < maxc), 256'(1));
  endtask

  // Scoreboard: compares every presented beat against the head of exp_q.
  always @(negedge clk) begin
    if (!i_rst) begin
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 256'(o_valid), 256'(0));
        end else begin
          mon_rec = exp_q[0];
          check("beat_idx", 256'(o_beat), 256'(exp_beat));
          check("word", 256'(o_word), 256'(mon_rec[exp_beat*32 +: 32]));
          check("last", 256'(o_last), 256'(exp_beat == 7));
          check("kp_x", 256'(o_kp_x), 256'(mon_rec[293:284]));
          check("kp_y", 256'(o_kp_y), 256'(mon_rec[283:274]));
          check("kp_score", 256'(o_kp_score), 256'(mon_rec[273:266]));
          check("kp_depth", 256'(o_kp_depth), 256'(mon_rec[265:256]));
          if (i_ready) begin
            if (exp_beat == 7) begin
              void'(exp_q.pop_front());
              exp_beat = 0;
              exp_kp++;
            end else begin
              exp_beat++;
            end
          end
        end
      end
      if (o_frame_done) begin
        fd_seen++;
        check("fd_fifo_empty", 256'(exp_q.size()), 256'(0));
        check("fd_kp_count", 256'(o_kp_count), 256'(exp_kp));
      end
      if (c_valid && i_ready && c_last) cap_emit++;
      if (cap_chk && c_frame_done) begin
        cap_fd++;
        check("cap_fd_emitted", 256'(cap_emit), 256'(3));
        check("cap_fd_kp_count", 256'(c_kp_count), 256'(3));
      end
    end
  end

  initial begin
    i_rst = 1'b1; i_frame_start = 1'b0; i_frame_end = 1'b0; i_flag = 1'b0; i_ready = 1'b1;
    i_coor_x = '0; i_coor_y = '0; i_score = '0; i_depth = '0; i_descriptor = '0;
    repeat (3) @(posedge clk); #1;
    clear_model();

    check("rst_valid", 256'(o_valid), 256'(0));
    check("rst_word", 256'(o_word), 256'(0));
    check("rst_beat", 256'(o_beat), 256'(0));
    check("rst_last", 256'(o_last), 256'(0));
    check("rst_kp_x", 256'(o_kp_x), 256'(0));
    check("rst_kp_y", 256'(o_kp_y), 256'(0));
    check("rst_kp_score", 256'(o_kp_score), 256'(0));
    check("rst_kp_depth", 256'(o_kp_depth), 256'(0));
    check("rst_frame_done", 256'(o_frame_done), 256'(0));
    check("rst_kp_count", 256'(o_kp_count), 256'(0));
    check("rst_drop_count", 256'(o_drop_count), 256'(0));
    check("rst_overflow", 256'(o_overflow), 256'(0));
    check("rst_state", 256'(o_state), 256'(0));
    i_rst = 1'b0;
    frame_start();

    // Single record, LSB-first beats
    push(10'd100, 10'd50, 8'h5a, 10'd7, {4{64'h0123456789ABCDEF}}, 1'b0);
    check("single_not_yet_valid", 256'(o_valid), 256'(0));
    wait_drain("single_drain", 60);
    check("single_kp_count", 256'(o_kp_count), 256'(1));

    // Backpressure with ready pattern 1,0,0,1
    push_rand(1'b0);
    begin
      int k = 0;
      while ((exp_q.size() != 0 || o_valid) && k < 100) begin
        i_ready = (k % 4 == 0) || (k % 4 == 3);
        @(posedge clk); #1;
        k++;
      end
      check("bp_drain", 256'(k < 100), 256'(1));
    end
    i_ready = 1'b1;
    check("bp_kp_count", 256'(o_kp_count), 256'(exp_kp));

    // Overflow: 10 back-to-back pushes while stalled
    i_ready = 1'b0;
    for (int i = 0; i < 10; i++) push_rand(1'b0);
    check("ovf_queued", 256'(exp_q.size()), 256'(8));
    check("ovf_drop_count", 256'(o_drop_count), 256'(exp_drop));
    check("ovf_drop_is_two", 256'(o_drop_count), 256'(2));
    check("ovf_flag", 256'(o_overflow), 256'(exp_ovf));
    i_ready = 1'b1;
    wait_drain("ovf_drain", 200);
    check("ovf_kp_count", 256'(o_kp_count), 256'(exp_kp));

    // Frame end coinciding with the second of two queued records
    push_rand(1'b0);
    push_rand(1'b1);
    check("fb_no_early_done", 256'(fd_seen), 256'(0));
    wait_fd("fb_frame_done", 100);
    check("fb_fifo_drained", 256'(exp_q.size()), 256'(0));
    check("fb_kp_count", 256'(o_kp_count), 256'(12));
    @(posedge clk); #1;
    check("fb_done_one_cycle", 256'(o_frame_done), 256'(0));
    frame_start();
    check("fs_kp_count", 256'(o_kp_count), 256'(0));
    check("fs_drop_count", 256'(o_drop_count), 256'(0));
    check("fs_overflow", 256'(o_overflow), 256'(0));

    // Randomized pushes with random ready and gaps
    for (int i = 0; i < 14; i++) begin
      push_rand(1'b0);
      repeat ($urandom_range(0, 3)) begin
        i_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end
    i_ready = 1'b1;
    wait_drain("rand_drain", 300);
    check("rand_drop_count", 256'(o_drop_count), 256'(exp_drop));
    check("rand_overflow", 256'(o_overflow), 256'(exp_ovf));
    check("rand_kp_count", 256'(o_kp_count), 256'(exp_kp));

    // Keypoint cap (second instance, MAX_KP=3)
    i_rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    clear_model();
    i_rst = 1'b0;
    frame_start();
    cap_chk = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_rand(1'b0);
      repeat (14) @(posedge clk);
      #1;
    end
    frame_end();
    wait_fd("cap_frame_done", 50);
    check("cap_fd_count", 256'(cap_fd), 256'(1));
    check("cap_drop_count", 256'(c_drop_count), 256'(0));
    check("cap_overflow", 256'(c_overflow), 256'(0));
    check("cap_emitted", 256'(cap_emit), 256'(3));
    check("main_kp_count", 256'(o_kp_count), 256'(5));
    cap_chk = 1'b0;

    // Reset in the middle of a record
    frame_start();
    push_rand(1'b0);
    begin
      int n = 0;
      while (!(o_valid && o_beat == 3'd3) && n < 30) begin
        @(posedge clk); #1;
        n++;
      end
      check("mid_reach_beat3", 256'(n < 30), 256'(1));
    end
    i_rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_valid", 256'(o_valid), 256'(0));
    check("mid_rst_beat", 256'(o_beat), 256'(0));
    check("mid_rst_kp_count", 256'(o_kp_count), 256'(0));
    check("mid_rst_drop_count", 256'(o_drop_count), 256'(0));
    check("mid_rst_overflow", 256'(o_overflow), 256'(0));
    clear_model();
    i_rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("mid_rst_quiet", 256'(o_valid), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
